fifo_burst_drain: RTL and testbench

Downstream consumer of `fifo_buffer_syn`. Pops words from the synchronous FIFO in bursts of `BURST_LEN` words and presents them on a valid/ready stream output, with `m_last` marking the final word of each burst. A short partial burst is flushed after `TIMEOUT` idle cycles so residual data never sits in the FIFO indefinitely. An internal 3-entry skid buffer absorbs the FIFO's one-cycle read latency and downstream backpressure.

---
 rtl/fifo_burst_drain.sv | 170 +++++++++++++++++
 tb/tb_fifo_burst_drain.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_burst_drain
// Purpose  : Pops a synchronous FIFO in bursts of BURST_LEN words, flushes
//            partial bursts after TIMEOUT idle cycles, and streams the words
//            out through a 3-entry skid buffer on a valid/ready/last port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    input  logic [ADDR_WIDTH-1:0] fifo_wd_cnt,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int              c_CW      = ADDR_WIDTH + 1;
    localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(2**ADDR_WIDTH);
    localparam logic [c_CW-1:0] c_BURST   = c_CW'(BURST_LEN);
    localparam logic [c_CW-1:0] c_TIMEOUT = c_CW'(TIMEOUT);
    localparam logic [c_CW-1:0] c_SLOTS   = c_CW'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_CW-1:0]       r_remain;
    logic [c_CW-1:0]       r_issue;
    logic [c_CW-1:0]       r_cap;
    logic [c_CW-1:0]       r_tcnt;
    logic [c_CW-1:0]       r_occ;
    logic                  r_inflight;
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic [DATA_WIDTH-1:0] r_buf_data [3];
    logic [2:0]            r_buf_last;

    logic [c_CW-1:0]       w_avail;
    logic [c_CW-1:0]       w_first;
    logic                  w_full_cond;
    logic                  w_tmo;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_credit;
    logic                  w_cap_last;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_head_last;

    // A full FIFO reports a zero word count, so substitute the depth.
    assign w_avail     = fifo_full ? c_DEPTH : {1'b0, fifo_wd_cnt};
    assign w_full_cond = (w_avail >= c_BURST);
    assign w_first     = w_full_cond ? c_BURST : w_avail;
    assign w_tmo       = !fifo_empty && (r_tcnt == c_TIMEOUT);
    assign w_start     = w_full_cond || w_tmo;

    assign m_valid     = (r_occ != '0);
    assign w_accept    = m_valid && m_ready;

    // Reserve a slot for every word already on its way; an accept this cycle frees one.
    assign w_credit    = ((r_occ + c_CW'(r_inflight) - c_CW'(w_accept)) < c_SLOTS);
    assign fifo_rd     = (r_state == S_BURST) && (r_issue != '0) && !fifo_empty && w_credit;

    assign w_cap_last  = ((r_cap + 1'b1) == r_remain);

    always_comb begin
        w_head_data = r_buf_data[0];
        w_head_last = r_buf_last[0];
        case (r_rptr)
            2'd1: begin
                w_head_data = r_buf_data[1];
                w_head_last = r_buf_last[1];
            end
            2'd2: begin
                w_head_data = r_buf_data[2];
                w_head_last = r_buf_last[2];
            end
            default: ;
        endcase
    end

    assign m_data = w_head_data;
    assign m_last = m_valid && w_head_last;
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_remain   <= '0;
            r_issue    <= '0;
            r_cap      <= '0;
            r_tcnt     <= '0;
            r_occ      <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
            r_buf_last <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_buf_data[i] <= '0;
            end
        end else begin
            r_inflight <= fifo_rd;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_BURST;
                        r_remain <= w_first;
                        r_issue  <= w_first;
                        r_cap    <= '0;
                        r_tcnt   <= '0;
                    end else if (fifo_empty) begin
                        r_tcnt <= '0;
                    end else if (r_tcnt != c_TIMEOUT) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_BURST: begin
                    if (fifo_rd) begin
                        r_issue <= r_issue - 1'b1;
                        if (r_issue == c_CW'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_accept && m_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // FIFO read data is valid one cycle after the pop strobe.
            if (r_inflight) begin
                r_buf_data[r_wptr] <= fifo_data;
                r_buf_last[r_wptr] <= w_cap_last;
                r_cap              <= r_cap + 1'b1;
                r_wptr             <= (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
            end

            if (w_accept) begin
                r_rptr <= (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
            end

            case ({r_inflight, w_accept})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_drain
// Purpose  : Directed self-checking bench with a behavioural upstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_drain;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW-1:0] fifo_wd_cnt;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;

    logic          wr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          fclr = 1'b0;
    logic [DW-1:0] mem [16];
    int            f_cnt = 0;
    int            f_wp = 0;
    int            f_rp = 0;

    int n_tests = 0;
    int n_fail  = 0;

    int            cyc = 0;
    logic [DW-1:0] out_q [$];
    logic          last_q [$];
    int            acc_q [$];
    int            rd_q [$];
    int            hold_err = 0;
    bit            hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic          hold_l = 1'b0;
    int            mv_cnt = 0;
    int            ne_cyc = -1;
    int            busy_rise = 0;
    int            busy_fall = -1;
    bit            busy_prev = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_LEN (4),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wd_cnt(fifo_wd_cnt),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    // Upstream synchronous FIFO: 16 deep, registered read data, count reads 0 when full.
    assign fifo_empty  = (f_cnt == 0);
    assign fifo_full   = (f_cnt == 16);
    assign fifo_wd_cnt = 4'(f_cnt);

    always @(posedge clk) begin
        if (fclr) begin
            f_cnt <= 0;
            f_wp  <= 0;
            f_rp  <= 0;
        end else begin
            if (wr && f_cnt < 16) begin
                mem[f_wp] <= wr_data;
                f_wp      <= (f_wp + 1) % 16;
            end
            if (fifo_rd && f_cnt != 0) begin
                fifo_data <= mem[f_rp];
                f_rp      <= (f_rp + 1) % 16;
            end
            f_cnt <= f_cnt + ((wr && f_cnt < 16) ? 1 : 0) - ((fifo_rd && f_cnt != 0) ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (fifo_rd) rd_q.push_back(cyc);
        if (m_valid && m_ready) begin
            out_q.push_back(m_data);
            last_q.push_back(m_last);
            acc_q.push_back(cyc);
        end
        if (m_valid && !m_ready) begin
            if (hold_v && (m_data !== hold_d || m_last !== hold_l)) hold_err = hold_err + 1;
            hold_v = 1'b1;
            hold_d = m_data;
            hold_l = m_last;
        end else begin
            hold_v = 1'b0;
        end
        if (m_valid) mv_cnt = mv_cnt + 1;
        if (!fifo_empty && ne_cyc < 0) ne_cyc = cyc;
        if (busy && !busy_prev) busy_rise = busy_rise + 1;
        if (!busy && busy_prev && busy_fall < 0) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        out_q.delete();
        last_q.delete();
        acc_q.delete();
        rd_q.delete();
        hold_err  = 0;
        mv_cnt    = 0;
        ne_cyc    = -1;
        busy_rise = 0;
        busy_fall = -1;
    endtask

    task automatic write_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr      = 1'b1;
            wr_data = base + DW'(i);
            tick(1);
        end
        wr = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        fclr = 1'b1;
        tick(2);
        n_tests++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_rd: got %b exp 0", fifo_rd); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b exp 0", m_valid); end
        n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b exp 0", m_last); end
        n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h exp 00", m_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        fclr = 1'b0;
        rst  = 1'b1;
        tick(2);
    endtask

    task automatic test_full_burst();
        clear_mon();
        m_ready = 1'b1;
        write_words(8'h11, 4);
        tick(20);
        n_tests++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL full_count: got %0d exp 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (out_q[i] !== 8'h11 + DW'(i)) begin n_fail++; $display("FAIL full_data[%0d]: got %h exp %h", i, out_q[i], 8'h11 + DW'(i)); end
            n_tests++; if (last_q[i] !== (i == 3)) begin n_fail++; $display("FAIL full_last[%0d]: got %b exp %b", i, last_q[i], (i == 3)); end
        end
        n_tests++; if (rd_q.size() !== 4) begin n_fail++; $display("FAIL full_pops: got %0d exp 4", rd_q.size()); end
        n_tests++; if (rd_q[0] - ne_cyc !== 4) begin n_fail++; $display("FAIL full_start_lat: got %0d exp 4", rd_q[0] - ne_cyc); end
        n_tests++; if (rd_q[3] - rd_q[0] !== 3) begin n_fail++; $display("FAIL full_rd_run: got %0d exp 3", rd_q[3] - rd_q[0]); end
        n_tests++; if (acc_q[0] - rd_q[0] !== 2) begin n_fail++; $display("FAIL full_valid_lat: got %0d exp 2", acc_q[0] - rd_q[0]); end
        n_tests++; if (acc_q[3] - acc_q[0] !== 3) begin n_fail++; $display("FAIL full_out_run: got %0d exp 3", acc_q[3] - acc_q[0]); end
        n_tests++; if (busy_fall !== acc_q[3] + 1) begin n_fail++; $display("FAIL full_busy_fall: got %0d exp %0d", busy_fall, acc_q[3] + 1); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_fifo_empty: got %b exp 1", fifo_empty); end
    endtask

    task automatic test_timeout();
        clear_mon();
        m_ready = 1'b1;
        write_words(8'hA0, 2);
        tick(40);
        n_tests++; if (rd_q[0] - ne_cyc !== 17) begin n_fail++; $display("FAIL tmo_delay: got %0d exp 17", rd_q[0] - ne_cyc); end
        n_tests++; if (rd_q.size() !== 2) begin n_fail++; $display("FAIL tmo_pops: got %0d exp 2", rd_q.size()); end
        n_tests++; if (out_q.size() !== 2) begin n_fail++; $display("FAIL tmo_count: got %0d exp 2", out_q.size()); end
        n_tests++; if (out_q[0] !== 8'hA0 || out_q[1] !== 8'hA1) begin n_fail++; $display("FAIL tmo_data: got %h %h exp a0 a1", out_q[0], out_q[1]); end
        n_tests++; if (last_q[0] !== 1'b0 || last_q[1] !== 1'b1) begin n_fail++; $display("FAIL tmo_last: got %b %b exp 0 1", last_q[0], last_q[1]); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_end: got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        clear_mon();
        m_ready = 1'b0;
        write_words(8'h11, 4);
        tick(20);
        n_tests++; if (rd_q.size() !== 3) begin n_fail++; $display("FAIL bp_pops_stalled: got %0d exp 3", rd_q.size()); end
        n_tests++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL bp_rd_low: got %b exp 0", fifo_rd); end
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b exp 1", m_valid); end
        n_tests++; if (m_data !== 8'h11) begin n_fail++; $display("FAIL bp_head: got %h exp 11", m_data); end
        n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL bp_head_last: got %b exp 0", m_last); end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes exp 0", hold_err); end
        m_ready = 1'b1;
        tick(20);
        n_tests++; if (out_q.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d exp 4", out_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (out_q[i] !== 8'h11 + DW'(i) || last_q[i] !== (i == 3)) begin n_fail++; $display("FAIL bp_word[%0d]: got %h/%b exp %h/%b", i, out_q[i], last_q[i], 8'h11 + DW'(i), (i == 3)); end
        end
        n_tests++; if (rd_q.size() !== 4) begin n_fail++; $display("FAIL bp_pops_total: got %0d exp 4", rd_q.size()); end
    endtask

    task automatic test_full_fifo();
        clear_mon();
        rst     = 1'b0;
        m_ready = 1'b1;
        write_words(8'h20, 16);
        rst = 1'b1;
        tick(80);
        n_tests++; if (out_q.size() !== 16) begin n_fail++; $display("FAIL ff_count: got %0d exp 16", out_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (out_q[i] !== 8'h20 + DW'(i) || last_q[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL ff_word[%0d]: got %h/%b exp %h/%b", i, out_q[i], last_q[i], 8'h20 + DW'(i), (i % 4 == 3)); end
        end
        n_tests++; if (busy_rise !== 4) begin n_fail++; $display("FAIL ff_bursts: got %0d exp 4", busy_rise); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL ff_fifo_empty: got %b exp 1", fifo_empty); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        m_ready = 1'b0;
        write_words(8'h50, 4);
        for (int k = 0; k < 20 && !m_valid; k++) tick(1);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL rm_fill: got m_valid=%b exp 1", m_valid); end
        tick(1);
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL rm_fifo_rd: got %b exp 0", fifo_rd); end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_m_valid: got %b exp 0", m_valid); end
        n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rm_m_last: got %b exp 0", m_last); end
        n_tests++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL rm_m_data: got %h exp 00", m_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b exp 0", busy); end
        tick(1);
        fclr = 1'b1;
        tick(2);
        fclr = 1'b0;
        rst  = 1'b1;
        clear_mon();
        m_ready = 1'b1;
        tick(10);
        n_tests++; if (mv_cnt !== 0) begin n_fail++; $display("FAIL rm_post_valid: got %0d cycles exp 0", mv_cnt); end
        n_tests++; if (busy_rise !== 0 || rd_q.size() !== 0) begin n_fail++; $display("FAIL rm_post_idle: got %0d bursts %0d pops exp 0 0", busy_rise, rd_q.size()); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        m_ready = 1'b1;
        write_words(8'h30, 8);
        tick(40);
        n_tests++; if (out_q.size() !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d exp 8", out_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (out_q[i] !== 8'h30 + DW'(i) || last_q[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h/%b exp %h/%b", i, out_q[i], last_q[i], 8'h30 + DW'(i), (i % 4 == 3)); end
        end
        n_tests++; if (rd_q[4] - acc_q[3] !== 2) begin n_fail++; $display("FAIL b2b_gap: got %0d exp 2", rd_q[4] - acc_q[3]); end
        n_tests++; if (busy_rise !== 2) begin n_fail++; $display("FAIL b2b_bursts: got %0d exp 2", busy_rise); end
    endtask

    task automatic test_stress();
        logic [DW-1:0] wq [$];
        int order_err;
        int burst_err;
        int run;
        clear_mon();
        for (int c = 0; c < 1000; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if (f_cnt < 16 && $urandom_range(0, 1) == 1) begin
                wr      = 1'b1;
                wr_data = DW'($urandom);
                wq.push_back(wr_data);
            end else begin
                wr = 1'b0;
            end
            tick(1);
        end
        wr      = 1'b0;
        m_ready = 1'b1;
        tick(100);
        order_err = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (i >= out_q.size() || out_q[i] !== wq[i]) order_err++;
        end
        burst_err = 0;
        run = 0;
        for (int i = 0; i < last_q.size(); i++) begin
            run++;
            if (run > 4 || (run == 4 && last_q[i] !== 1'b1)) burst_err++;
            if (last_q[i] === 1'b1) run = 0;
        end
        if (run != 0) burst_err++;
        n_tests++; if (out_q.size() !== wq.size()) begin n_fail++; $display("FAIL stress_count: got %0d exp %0d", out_q.size(), wq.size()); end
        n_tests++; if (order_err !== 0) begin n_fail++; $display("FAIL stress_order: got %0d bad words exp 0", order_err); end
        n_tests++; if (burst_err !== 0) begin n_fail++; $display("FAIL stress_last: got %0d bad bursts exp 0", burst_err); end
        n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL stress_stable: got %0d changes exp 0", hold_err); end
        n_tests++; if (fifo_empty !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stress_end: got empty=%b busy=%b exp 1 0", fifo_empty, busy); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_timeout();
        test_backpressure();
        test_full_fifo();
        test_reset_mid();
        test_back_to_back();
        test_stress();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion exp finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
